// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control symbols, the lock FSM state type
// and a control-symbol matcher used by both encoder and decoder sides.
package tmds_pkg;

    localparam logic [9:0] CTRL_SYM_00 = 10'h354;
    localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
    localparam logic [9:0] CTRL_SYM_10 = 10'h154;
    localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } lock_state_t;

    // Returns {hit, code}; code is meaningful only when hit is set
    function automatic logic [2:0] match_ctrl(input logic [9:0] sym);
        case (sym)
            CTRL_SYM_00: return 3'b100;
            CTRL_SYM_01: return 3'b101;
            CTRL_SYM_10: return 3'b110;
            CTRL_SYM_11: return 3'b111;
            default:     return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/tmds_lock_fsm.sv
// Symbol-boundary lock tracker: counts control-symbol runs, requests bitslips
// while searching and detects lock loss. Optional err_count via TMDS_DECODER_ERRCNT_EN.
module tmds_lock_fsm
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN  = 8,
    parameter int WINDOW    = 4096,
    parameter int SLIP_WAIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        valid,
    input  logic        is_ctrl,
    output logic        locked,
    output logic        bitslip
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int RUN_W  = $clog2(CTRL_RUN + 1);
    localparam int HOLD_W = $clog2(SLIP_WAIT + 1);

    lock_state_t       state, state_nxt;
    logic [WIN_W-1:0]  win_cnt, win_nxt;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              slip_nxt;
    logic              lost;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state    <= SEARCH;
            win_cnt  <= '0;
            run_cnt  <= '0;
            hold_cnt <= '0;
            bitslip  <= 1'b0;
        end else begin
            state    <= state_nxt;
            win_cnt  <= win_nxt;
            run_cnt  <= run_nxt;
            hold_cnt <= hold_nxt;
            bitslip  <= slip_nxt;
        end
    end

    // Lock completion is tested before window expiry so a simultaneous
    // finish locks rather than slips
    always_comb begin
        state_nxt = state;
        win_nxt   = win_cnt;
        run_nxt   = run_cnt;
        hold_nxt  = hold_cnt;
        slip_nxt  = 1'b0;
        lost      = 1'b0;
        case (state)
            SEARCH: begin
                if (valid) begin
                    if (is_ctrl) begin
                        run_nxt = (run_cnt == RUN_W'(CTRL_RUN)) ? run_cnt : run_cnt + 1'b1;
                    end else begin
                        run_nxt = '0;
                    end
                    if (is_ctrl && (run_nxt == RUN_W'(CTRL_RUN))) begin
                        state_nxt = LOCKED;
                        run_nxt   = '0;
                        win_nxt   = '0;
                    end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        state_nxt = SLIP_HOLD;
                        slip_nxt  = 1'b1;
                        run_nxt   = '0;
                        win_nxt   = '0;
                        hold_nxt  = '0;
                    end else begin
                        win_nxt = win_cnt + 1'b1;
                    end
                end
            end
            SLIP_HOLD: begin
                if (hold_cnt == HOLD_W'(SLIP_WAIT - 1)) begin
                    state_nxt = SEARCH;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (valid) begin
                    if (is_ctrl) begin
                        win_nxt = '0;
                    end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                        state_nxt = SEARCH;
                        win_nxt   = '0;
                        run_nxt   = '0;
                        lost      = 1'b1;
                    end else begin
                        win_nxt = win_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = SEARCH;
                win_nxt   = '0;
                run_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    assign locked = (state == LOCKED);

`ifdef TMDS_DECODER_ERRCNT_EN
    // Alignment trouble events: each slip request and each loss of lock
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            err_count <= '0;
        end else if ((slip_nxt || lost) && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 1'b1;
        end
    end
`else
    logic unused_lost;
    assign unused_lost = lost;
`endif

endmodule

// File: rtl/tmds_decoder.sv
// One-channel TMDS decoder: 2-stage decode pipeline plus lock/bitslip tracking.
// Optional err_count_out port enabled by TMDS_DECODER_ERRCNT_EN.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN  = 8,
    parameter int WINDOW    = 4096,
    parameter int SLIP_WAIT = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  symbol_in,
    input  logic        valid_in,
    output logic [7:0]  data_out,
    output logic [1:0]  ctrl_out,
    output logic        de_out,
    output logic        valid_out,
    output logic        locked_out,
    output logic        bitslip_out
`ifdef TMDS_DECODER_ERRCNT_EN
    ,
    output logic [15:0] err_count_out
`endif
);

    logic [9:0] sym_s1;
    logic       valid_s1;
    logic       is_ctrl_s1;
    logic [1:0] code_s1;
    logic [7:0] d_s1;
    logic [7:0] dec_s1;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sym_s1   <= '0;
            valid_s1 <= 1'b0;
        end else begin
            sym_s1   <= symbol_in;
            valid_s1 <= valid_in;
        end
    end

    // Undo DC-balance inversion, then the XOR/XNOR transition chain
    always_comb begin
        {is_ctrl_s1, code_s1} = match_ctrl(sym_s1);
        d_s1      = sym_s1[9] ? ~sym_s1[7:0] : sym_s1[7:0];
        dec_s1    = '0;
        dec_s1[0] = d_s1[0];
        for (int i = 1; i < 8; i++) begin
            dec_s1[i] = sym_s1[8] ? (d_s1[i] ^ d_s1[i-1]) : ~(d_s1[i] ^ d_s1[i-1]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            data_out  <= '0;
            ctrl_out  <= '0;
            de_out    <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_s1;
            if (valid_s1) begin
                if (is_ctrl_s1) begin
                    de_out   <= 1'b0;
                    ctrl_out <= code_s1;
                end else begin
                    de_out   <= 1'b1;
                    data_out <= dec_s1;
                end
            end
        end
    end

    tmds_lock_fsm #(
        .CTRL_RUN  (CTRL_RUN),
        .WINDOW    (WINDOW),
        .SLIP_WAIT (SLIP_WAIT)
    ) u_lock (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .valid     (valid_s1),
        .is_ctrl   (is_ctrl_s1),
        .locked    (locked_out),
        .bitslip   (bitslip_out)
`ifdef TMDS_DECODER_ERRCNT_EN
        ,
        .err_count (err_count_out)
`endif
    );

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder using a reference TMDS encoder.
// Exercises err_count_out when TMDS_DECODER_ERRCNT_EN is defined.
module tb_tmds_decoder;

    localparam int WINDOW    = 4096;
    localparam int SLIP_WAIT = 16;
    localparam int N_DATA    = 264;

    logic        clk_in;
    logic        rst_in;
    logic [9:0]  symbol_in;
    logic        valid_in;
    logic [7:0]  data_out;
    logic [1:0]  ctrl_out;
    logic        de_out;
    logic        valid_out;
    logic        locked_out;
    logic        bitslip_out;
`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] err_count_out;
`endif

    int checks = 0;
    int passed = 0;
    int slipViol = 0;
    logic prevSlip = 1'b0;

    tmds_decoder #(
        .CTRL_RUN  (8),
        .WINDOW    (WINDOW),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .symbol_in     (symbol_in),
        .valid_in      (valid_in),
        .data_out      (data_out),
        .ctrl_out      (ctrl_out),
        .de_out        (de_out),
        .valid_out     (valid_out),
        .locked_out    (locked_out),
        .bitslip_out   (bitslip_out)
`ifdef TMDS_DECODER_ERRCNT_EN
        ,
        .err_count_out (err_count_out)
`endif
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // A slip request must never coincide with lock or repeat on back-to-back cycles
    always @(negedge clk_in) begin
        if (bitslip_out && (locked_out || prevSlip)) slipViol++;
        prevSlip = bitslip_out;
    end

    function automatic logic [9:0] tmdsEncode(input logic [7:0] d, input logic inv);
        logic [7:0] qm;
        logic       useXnor;
        int         ones;
        ones    = $countones(d);
        useXnor = (ones > 4) || ((ones == 4) && (d[0] == 1'b0));
        qm[0]   = d[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = useXnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        end
        return {inv, ~useXnor, inv ? ~qm : qm};
    endfunction

    function automatic logic [9:0] rotl10(input logic [9:0] s, input int n);
        logic [19:0] t;
        t = {s, s} << n;
        return t[19:10];
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] sym, input logic vld);
        symbol_in = sym;
        valid_in  = vld;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic resetDut();
        rst_in = 1'b0;
        applyStimulus(10'h000, 1'b0);
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    logic [7:0] bytes   [N_DATA];
    logic       invs    [N_DATA];
    logic [7:0] fixedB  [4];
    int         slipSeen;
    int         slips;
    int         lastSlip;
    int         minGap;
    int         offset;
`ifdef TMDS_DECODER_ERRCNT_EN
    logic [15:0] errBefore;
`endif

    initial begin
        rst_in = 1'b0;
        applyStimulus(10'h000, 1'b0);
        tick();
        tick();
        checkOutput("reset_outputs",
                    {18'h0, data_out, ctrl_out, de_out, valid_out, locked_out, bitslip_out},
                    32'h0);
        rst_in = 1'b1;
        tick();
        checkOutput("valid_after_release", {31'h0, valid_out}, 32'h0);

        // Aligned control run straight after reset
        slipSeen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(10'h354, 1'b1);
            tick();
            if (bitslip_out) slipSeen++;
        end
        checkOutput("not_locked_after_7", {31'h0, locked_out}, 32'h0);
        applyStimulus(10'h000, 1'b0);
        tick();
        if (bitslip_out) slipSeen++;
        checkOutput("locked_after_8", {31'h0, locked_out}, 32'h1);
        checkOutput("no_slip_aligned", slipSeen, 32'd0);
        checkOutput("ctrl_after_run", {29'h0, de_out, ctrl_out}, {29'h0, 1'b0, 2'b00});

        // Data stream: fixed corners in both inversion states, then random bytes
        fixedB[0] = 8'h00; fixedB[1] = 8'hFF; fixedB[2] = 8'h55; fixedB[3] = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            bytes[i] = fixedB[i/2];
            invs[i]  = i[0];
        end
        for (int i = 8; i < N_DATA; i++) begin
            bytes[i] = 8'($urandom_range(255, 0));
            invs[i]  = 1'($urandom_range(1, 0));
        end
        checkOutput("enc_00_noinv", {22'h0, tmdsEncode(8'h00, 1'b0)}, 32'h100);
        checkOutput("enc_00_inv",   {22'h0, tmdsEncode(8'h00, 1'b1)}, 32'h3FF);
        for (int i = 0; i <= N_DATA; i++) begin
            if (i < N_DATA) applyStimulus(tmdsEncode(bytes[i], invs[i]), 1'b1);
            else            applyStimulus(10'h000, 1'b0);
            tick();
            if (i >= 1) begin
                checkOutput($sformatf("data_%0d", i - 1),
                            {22'h0, valid_out, de_out, data_out},
                            {22'h0, 1'b1, 1'b1, bytes[i-1]});
            end
        end
        tick();
        checkOutput("bubble_hold", {22'h0, valid_out, de_out, data_out},
                    {22'h0, 1'b0, 1'b1, bytes[N_DATA-1]});

        // Control symbols keep the last data byte
        applyStimulus(tmdsEncode(8'h5A, 1'b1), 1'b1);
        tick();
        applyStimulus(10'h354, 1'b1);
        tick();
        checkOutput("data_5A", {22'h0, valid_out, de_out, data_out}, {22'h0, 2'b11, 8'h5A});
        applyStimulus(10'h0AB, 1'b1);
        tick();
        checkOutput("ctrl_00", {20'h0, valid_out, de_out, ctrl_out, data_out}, {20'h0, 2'b10, 2'b00, 8'h5A});
        applyStimulus(10'h154, 1'b1);
        tick();
        checkOutput("ctrl_01", {20'h0, valid_out, de_out, ctrl_out, data_out}, {20'h0, 2'b10, 2'b01, 8'h5A});
        applyStimulus(10'h2AB, 1'b1);
        tick();
        checkOutput("ctrl_10", {20'h0, valid_out, de_out, ctrl_out, data_out}, {20'h0, 2'b10, 2'b10, 8'h5A});
        applyStimulus(10'h000, 1'b0);
        tick();
        checkOutput("ctrl_11", {20'h0, valid_out, de_out, ctrl_out, data_out}, {20'h0, 2'b10, 2'b11, 8'h5A});

        // Misaligned by 3 bits; each bitslip rotates the delivered stream back by 1
        resetDut();
        offset   = 3;
        slips    = 0;
        lastSlip = 0;
        minGap   = 1 << 30;
        for (int cyc = 0; cyc < 20000 && !locked_out; cyc++) begin
            applyStimulus(rotl10(10'h354, offset), 1'b1);
            tick();
            if (bitslip_out) begin
                if (slips > 0 && (cyc - lastSlip) < minGap) minGap = cyc - lastSlip;
                lastSlip = cyc;
                slips++;
                offset = (offset == 0) ? 9 : offset - 1;
            end
        end
        checkOutput("slip_locked", {31'h0, locked_out}, 32'h1);
        checkOutput("slip_count", slips, 32'd3);
        checkOutput("slip_gap_ok", {31'h0, (minGap >= WINDOW + SLIP_WAIT)}, 32'h1);
`ifdef TMDS_DECODER_ERRCNT_EN
        checkOutput("err_after_slips", {16'h0, err_count_out}, 32'd3);
        errBefore = err_count_out;
`endif

        // Lock loss after WINDOW consecutive data symbols
        for (int i = 0; i < WINDOW; i++) begin
            applyStimulus(10'h100, 1'b1);
            tick();
        end
        checkOutput("still_locked_4095", {31'h0, locked_out}, 32'h1);
        applyStimulus(10'h100, 1'b1);
        tick();
        checkOutput("lock_lost_4096", {30'h0, locked_out, bitslip_out}, 32'h0);
`ifdef TMDS_DECODER_ERRCNT_EN
        checkOutput("err_after_loss", {16'h0, err_count_out}, {16'h0, errBefore + 16'd1});
`endif
        for (int i = 0; i < 8; i++) begin
            applyStimulus(10'h354, 1'b1);
            tick();
        end
        applyStimulus(10'h000, 1'b0);
        tick();
        checkOutput("relocked", {31'h0, locked_out}, 32'h1);

        // Single-cycle reset while locked and streaming
        applyStimulus(tmdsEncode(8'h3C, 1'b0), 1'b1);
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        checkOutput("midreset_outputs",
                    {18'h0, data_out, ctrl_out, de_out, valid_out, locked_out, bitslip_out},
                    32'h0);
        rst_in = 1'b1;
        applyStimulus(10'h000, 1'b0);
        tick();
        checkOutput("midreset_flushed", {31'h0, valid_out}, 32'h0);
        applyStimulus(tmdsEncode(8'hC3, 1'b1), 1'b1);
        tick();
        checkOutput("midreset_lat1", {31'h0, valid_out}, 32'h0);
        applyStimulus(10'h000, 1'b0);
        tick();
        checkOutput("midreset_lat2", {22'h0, valid_out, de_out, data_out}, {22'h0, 2'b11, 8'hC3});
        checkOutput("midreset_search", {31'h0, locked_out}, 32'h0);

        checkOutput("slip_rules", slipViol, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
